// File: rtl/wb_ram_slave.sv
// Wishbone classic responder around a single-port 32-bit word RAM.
// One ack or err per accepted request after WAIT_STATES extra cycles; cyc low aborts silently.
module wb_ram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_wb_stall
);

    localparam int         DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [31:0] req_addr_p0;
    logic        req_we_p0;
    logic [31:0] req_data_p0;
    logic [3:0]  req_sel_p0;

    logic [31:0] cur_addr;
    logic        cur_we;
    logic [31:0] cur_data;
    logic [3:0]  cur_sel;
    logic        cur_hit;
    logic [ADDR_WIDTH-1:0] cur_idx;

    logic accept;
    logic enter_resp;

    logic [31:0] mem [DEPTH];

    function automatic logic addr_hit(input logic [31:0] a);
        return ((a >> (ADDR_WIDTH + 2)) == (BASE_ADDR >> (ADDR_WIDTH + 2))) &&
               (a[1:0] == 2'b00);
    endfunction

    assign accept     = (state_q == S_IDLE) && i_wb_cyc && i_wb_stb;
    assign o_wb_stall = (state_q != S_IDLE);

    // With no wait states the response is formed at the accepting edge, so the live bus is used.
    always_comb begin
        cur_addr = req_addr_p0;
        cur_we   = req_we_p0;
        cur_data = req_data_p0;
        cur_sel  = req_sel_p0;
        if (state_q == S_IDLE) begin
            cur_addr = i_wb_addr;
            cur_we   = i_wb_we;
            cur_data = i_wb_data;
            cur_sel  = i_wb_sel;
        end
    end

    assign cur_hit = addr_hit(cur_addr);
    assign cur_idx = cur_addr[ADDR_WIDTH+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
            o_wb_data   <= 32'd0;
            req_addr_p0 <= 32'd0;
            req_we_p0   <= 1'b0;
            req_data_p0 <= 32'd0;
            req_sel_p0  <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            o_wb_ack <= enter_resp && cur_hit;
            o_wb_err <= enter_resp && !cur_hit;
            if (accept) begin
                req_addr_p0 <= i_wb_addr;
                req_we_p0   <= i_wb_we;
                req_data_p0 <= i_wb_data;
                req_sel_p0  <= i_wb_sel;
            end
            if (enter_resp && cur_hit && !cur_we) begin
                o_wb_data <= mem[cur_idx];
            end
        end
    end

    // RAM contents survive reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_hit && cur_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized self-checking bench for wb_ram_slave: three instances (0, 3 and 2 wait states)
// compared against a word-array reference model of the bus contract.
module tb_wb_ram_slave;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cyc, stb;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rdata [3];
    logic [2:0]  ack, err, stall;

    int checks   = 0;
    int failures = 0;
    int cur_inst = 0;

    logic [31:0] mem_m [3][1024];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;

    wb_ram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_data(rdata[0]),
        .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_stall(stall[0]));

    wb_ram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_data(rdata[1]),
        .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_stall(stall[1]));

    wb_ram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_4000), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_data(rdata[2]),
        .o_wb_ack(ack[2]), .o_wb_err(err[2]), .o_wb_stall(stall[2]));

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 3 : 2;
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 2) ? 32'h0000_4000 : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", tag, cur_inst, got, exp, $time);
        end
    endtask

    // One bus transaction; abort_at >= 0 drops cyc after that many wait cycles.
    task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit pulse, input int abort_at, input bit extra);
        int ws;
        bit hit;
        int idx;
        ws  = ws_of(i);
        hit = ((a >> (AW + 2)) == (base_of(i) >> (AW + 2))) && (a[1:0] == 2'b00);
        idx = int'((a >> 2) & 32'h3FF);
        cur_inst = i;
        @(negedge clk);
        check("idle_stall", 32'(stall[i]), 32'd0);
        cyc[i] = 1'b1; stb[i] = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk);
        for (int j = 0; j <= ws; j++) begin
            @(negedge clk);
            check("busy_stall", 32'(stall[i]), 32'd1);
            if (j < ws) begin
                check("early_ack", 32'(ack[i]), 32'd0);
                check("early_err", 32'(err[i]), 32'd0);
            end else begin
                if (hit && w) mem_m[i][idx] = merge(mem_m[i][idx], d, s);
                if (hit && !w) last_rd[i] = mem_m[i][idx];
                check("ack", 32'(ack[i]), 32'(hit));
                check("err", 32'(err[i]), 32'(!hit));
            end
            check("rdata", rdata[i], last_rd[i]);
            if (pulse) stb[i] = 1'b0;
            if (extra && j == 1) begin
                stb[i] = 1'b1;
                addr   = a + 32'd4;
            end
            if (j == abort_at) begin
                cyc[i] = 1'b0; stb[i] = 1'b0;
                break;
            end
            if (j == ws) begin
                cyc[i] = 1'b0; stb[i] = 1'b0;
            end
        end
        @(negedge clk);
        check("post_stall", 32'(stall[i]), 32'd0);
        check("post_ack", 32'(ack[i]), 32'd0);
        check("post_err", 32'(err[i]), 32'd0);
        check("post_rdata", rdata[i], last_rd[i]);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            last_rd[i] = 32'd0;
            for (int k = 0; k < 1024; k++) mem_m[i][k] = 32'd0;
        end
        reset = 1'b0; cyc = 3'b111; stb = 3'b111; we = 1'b1;
        addr = 32'h10; wdata = 32'h5555_AAAA; sel = 4'hF;

        // Reset held with an active request on every instance.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                cur_inst = i;
                check("rst_ack", 32'(ack[i]), 32'd0);
                check("rst_err", 32'(err[i]), 32'd0);
                check("rst_stall", 32'(stall[i]), 32'd0);
                check("rst_rdata", rdata[i], 32'd0);
            end
        end
        reset = 1'b1; cyc = 3'b000; stb = 3'b000;

        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 32; w++)
                txn(i, 1'b1, base_of(i) + 32'(4 * w), $urandom, 4'hF, 1'b0, -1, 1'b0);

        // Zero wait states: full word, then byte lanes, then errors.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, -1, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, -1, 1'b0);
        cur_inst = 0; check("rd_full", rdata[0], 32'hDEADBEEF);
        txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1, -1, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, -1, 1'b0);
        cur_inst = 0; check("rd_lanes", rdata[0], 32'hDE22BE44);
        txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1, -1, 1'b0);
        txn(0, 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 1'b1, -1, 1'b0);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, -1, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, -1, 1'b0);
        cur_inst = 0; check("rd_after_err", rdata[0], 32'hDE22BE44);
        txn(0, 1'b1, 32'h14, 32'h0BAD_0BAD, 4'h0, 1'b1, -1, 1'b0);

        // Three wait states, single-cycle strobe plus a stray strobe during the wait.
        txn(1, 1'b1, 32'h20, 32'h0BADC0DE, 4'hF, 1'b1, -1, 1'b0);
        txn(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, -1, 1'b1);
        cur_inst = 1; check("rd_ws3", rdata[1], 32'h0BADC0DE);

        // Reset during WAIT: no termination, write dropped, bus usable afterwards.
        cur_inst = 1;
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; sel = 4'hF;
        @(negedge clk);
        check("rw_stall0", 32'(stall[1]), 32'd1);
        stb[1] = 1'b0;
        @(negedge clk);
        check("rw_stall1", 32'(stall[1]), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rw_stall", 32'(stall[1]), 32'd0);
        check("rw_ack", 32'(ack[1]), 32'd0);
        check("rw_err", 32'(err[1]), 32'd0);
        check("rw_rdata", rdata[1], 32'd0);
        for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
        reset = 1'b1; cyc[1] = 1'b0;
        @(negedge clk);
        check("rw_ack_late", 32'(ack[1]), 32'd0);
        txn(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, -1, 1'b0);

        // Two wait states, offset window: abort one cycle after acceptance, out-of-window err.
        txn(2, 1'b1, 32'h4030, 32'h1234_5678, 4'hF, 1'b1, 0, 1'b0);
        txn(2, 1'b0, 32'h4030, 32'h0, 4'hF, 1'b1, -1, 1'b0);
        txn(2, 1'b1, 32'h4034, 32'h8765_4321, 4'hF, 1'b0, 1, 1'b0);
        txn(2, 1'b0, 32'h4034, 32'h0, 4'hF, 1'b1, -1, 1'b0);
        txn(2, 1'b0, 32'h0030, 32'h0, 4'hF, 1'b1, -1, 1'b0);
        txn(2, 1'b1, 32'h0030, 32'hFFFF_FFFF, 4'hF, 1'b1, -1, 1'b0);
        txn(2, 1'b0, 32'h4030, 32'h0, 4'hF, 1'b1, -1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 60; n++) begin
                int r;
                int ab;
                logic [31:0] a;
                r = int'($urandom_range(0, 9));
                a = base_of(i) + 32'(4 * $urandom_range(0, 31));
                if (r == 8) a = a | 32'($urandom_range(1, 3));
                if (r == 9) a = a + 32'h1000 * 32'($urandom_range(1, 8));
                ab = -1;
                if (ws_of(i) > 0 && $urandom_range(0, 7) == 0)
                    ab = int'($urandom_range(0, ws_of(i) - 1));
                txn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                    1'($urandom_range(0, 1)), ab, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
